ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand forwarding, sitting directly upstream of the ALU.
- Latches decoded fields from ID and resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives the ALU operands, the ALU function code and the forwarded store data.
- Detects load-use hazards and requests a one-cycle stall from the front end.

---
 rtl/ex_operand_stage_pkg.sv | 28 ++
 rtl/ex_operand_stage_if.sv | 68 ++++++
 rtl/ex_operand_stage_fwd_mux.sv | 42 ++++
 rtl/ex_operand_stage.sv | 121 ++++++++++++
 tb/tb_ex_operand_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared CPU constants: ALU function codes, forwarding selects, datapath defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int CPU_RA_W  = 5;

  // ALU function encoding shared by decode, EX and the ALU itself
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_EQ   = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SLA  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  // Operand source chosen by the forwarding mux
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of ID fields, MEM/WB bypass sources and EX outputs around the operand stage.
// Latency: n/a (wiring only).
// Backpressure: stall_req flows back to the front end; everything else is forward-only.
interface ex_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);

  logic             flush;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_rs1_data;
  logic [WIDTH-1:0] id_rs2_data;
  logic [WIDTH-1:0] id_imm;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  id_rd;
  logic [3:0]       id_alu_func;
  logic             id_src1_pc;
  logic             id_src2_imm;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;

  logic [RA_W-1:0]  mem_rd;
  logic             mem_reg_write;
  logic [WIDTH-1:0] mem_result;
  logic [RA_W-1:0]  wb_rd;
  logic             wb_reg_write;
  logic [WIDTH-1:0] wb_result;

  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [3:0]       alu_func;
  logic [WIDTH-1:0] ex_store_data;
  logic             ex_valid;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic [RA_W-1:0]  ex_rd;
  logic [WIDTH-1:0] ex_pc;
  logic             stall_req;
  logic [1:0]       fwd1_sel;
  logic [1:0]       fwd2_sel;

  // Pipeline side: drives ID fields and bypass sources, consumes EX outputs
  modport master (
    output flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_func, id_src1_pc, id_src2_imm,
           id_reg_write, id_mem_read, id_mem_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    input  alu_src1, alu_src2, alu_func, ex_store_data, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc,
           stall_req, fwd1_sel, fwd2_sel
  );

  // Operand stage side
  modport slave (
    input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_func, id_src1_pc, id_src2_imm,
           id_reg_write, id_mem_read, id_mem_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    output alu_src1, alu_src2, alu_func, ex_store_data, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc,
           stall_req, fwd1_sel, fwd2_sel
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Bypass mux for one source register: MEM result, else WB result, else register data.
// Latency: combinational, zero cycles.
// Backpressure: none; load-use cases are kept out of MEM by the stage's stall.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int RA_W  = CPU_RA_W
) (
  input  logic [RA_W-1:0]  rs_i,
  input  logic [WIDTH-1:0] reg_data_i,
  input  logic [RA_W-1:0]  mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [WIDTH-1:0] mem_result_i,
  input  logic [RA_W-1:0]  wb_rd_i,
  input  logic             wb_reg_write_i,
  input  logic [WIDTH-1:0] wb_result_i,
  output logic [WIDTH-1:0] fwd_data_o,
  output logic [1:0]       fwd_sel_o
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a write to it must never be bypassed
  assign mem_hit = mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i);
  assign wb_hit  = wb_reg_write_i  && (wb_rd_i  != '0) && (wb_rd_i  == rs_i);

  // Youngest producer wins: MEM is newer than WB
  always_comb begin
    fwd_sel_o  = FWD_NONE;
    fwd_data_o = reg_data_i;
    if (mem_hit) begin
      fwd_sel_o  = FWD_MEM;
      fwd_data_o = mem_result_i;
    end else if (wb_hit) begin
      fwd_sel_o  = FWD_WB;
      fwd_data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB operand forwarding and load-use stall detection.
// Latency: 1 cycle ID fields -> ALU operands; forwarding adds none.
// Backpressure: stall_req (combinational) holds ID one cycle while a bubble enters EX.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int RA_W  = CPU_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic [RA_W-1:0]  rd;
    logic [3:0]       func;
    logic             src1_pc;
    logic             src2_imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } ex_regs_t;

  ex_regs_t         ex_q;
  ex_regs_t         ex_d;
  logic             stall_req;
  logic             id_reads_rs2;
  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;

  // rs2 is a real source for reg-reg ops and for stores (store data)
  assign id_reads_rs2 = !bus.id_src2_imm || bus.id_mem_write;

  // Load in EX whose destination is read by ID: its data only exists after MEM
  always_comb begin
    stall_req = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                ((ex_q.rd == bus.id_rs1) ||
                 (id_reads_rs2 && (ex_q.rd == bus.id_rs2)));
  end

  // Next EX contents: bubble on flush or stall, else capture ID
  always_comb begin
    ex_d = '0;
    if (!(bus.flush || stall_req)) begin
      ex_d.valid     = bus.id_valid;
      ex_d.pc        = bus.id_pc;
      ex_d.rs1_data  = bus.id_rs1_data;
      ex_d.rs2_data  = bus.id_rs2_data;
      ex_d.imm       = bus.id_imm;
      ex_d.rs1       = bus.id_rs1;
      ex_d.rs2       = bus.id_rs2;
      ex_d.rd        = bus.id_rd;
      ex_d.func      = bus.id_alu_func;
      ex_d.src1_pc   = bus.id_src1_pc;
      ex_d.src2_imm  = bus.id_src2_imm;
      // An empty ID slot must not carry side effects down the pipe
      ex_d.reg_write = bus.id_valid && bus.id_reg_write;
      ex_d.mem_read  = bus.id_valid && bus.id_mem_read;
      ex_d.mem_write = bus.id_valid && bus.id_mem_write;
    end
  end

  // ID/EX pipeline register; reset value is the same all-zero bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_i            (ex_q.rs1),
    .reg_data_i      (ex_q.rs1_data),
    .mem_rd_i        (bus.mem_rd),
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_result_i    (bus.mem_result),
    .wb_rd_i         (bus.wb_rd),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_result_i     (bus.wb_result),
    .fwd_data_o      (fwd_rs1),
    .fwd_sel_o       (bus.fwd1_sel)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_i            (ex_q.rs2),
    .reg_data_i      (ex_q.rs2_data),
    .mem_rd_i        (bus.mem_rd),
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_result_i    (bus.mem_result),
    .wb_rd_i         (bus.wb_rd),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_result_i     (bus.wb_result),
    .fwd_data_o      (fwd_rs2),
    .fwd_sel_o       (bus.fwd2_sel)
  );

  // Operand selection and EX-side outputs
  always_comb begin
    bus.alu_src1      = ex_q.src1_pc  ? ex_q.pc  : fwd_rs1;
    bus.alu_src2      = ex_q.src2_imm ? ex_q.imm : fwd_rs2;
    bus.ex_store_data = fwd_rs2;
    bus.alu_func      = ex_q.func;
    bus.ex_valid      = ex_q.valid;
    bus.ex_reg_write  = ex_q.reg_write;
    bus.ex_mem_read   = ex_q.mem_read;
    bus.ex_mem_write  = ex_q.mem_write;
    bus.ex_rd         = ex_q.rd;
    bus.ex_pc         = ex_q.pc;
    bus.stall_req     = stall_req;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage with an expectation queue.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: the bench holds ID steady across a stall, as the front end would.
module tb_ex_operand_stage;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        vld;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  ex_operand_stage_if #(.WIDTH(32), .RA_W(5)) bus ();

  ex_operand_stage #(.WIDTH(32), .RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [31:0] rs1d,
                        input logic [4:0] rs2, input logic [31:0] rs2d,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [3:0] fn, input logic s1pc, input logic s2imm,
                        input logic rw, input logic mr, input logic mw);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs1       = rs1;
    bus.id_rs1_data  = rs1d;
    bus.id_rs2       = rs2;
    bus.id_rs2_data  = rs2d;
    bus.id_imm       = imm;
    bus.id_rd        = rd;
    bus.id_alu_func  = fn;
    bus.id_src1_pc   = s1pc;
    bus.id_src2_imm  = s2imm;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  task automatic id_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    bus.mem_rd        = mrd;
    bus.mem_reg_write = mrw;
    bus.mem_result    = mres;
    bus.wb_rd         = wrd;
    bus.wb_reg_write  = wrw;
    bus.wb_result     = wres;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] st, input logic [3:0] fn, input logic [4:0] rd,
                            input logic v, input logic rw, input logic mr, input logic mw,
                            input logic stl);
    exp_t e;
    e.src1 = s1; e.src2 = s2; e.store = st; e.func = fn; e.rd = rd;
    e.vld = v; e.rw = rw; e.mr = mr; e.mw = mw; e.stall = stl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp({t, ".alu_src1"},      bus.alu_src1,              e.src1);
    cmp({t, ".alu_src2"},      bus.alu_src2,              e.src2);
    cmp({t, ".store_data"},    bus.ex_store_data,         e.store);
    cmp({t, ".alu_func"},      {28'd0, bus.alu_func},     {28'd0, e.func});
    cmp({t, ".ex_rd"},         {27'd0, bus.ex_rd},        {27'd0, e.rd});
    cmp({t, ".ex_valid"},      {31'd0, bus.ex_valid},     {31'd0, e.vld});
    cmp({t, ".ex_reg_write"},  {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
    cmp({t, ".ex_mem_read"},   {31'd0, bus.ex_mem_read},  {31'd0, e.mr});
    cmp({t, ".ex_mem_write"},  {31'd0, bus.ex_mem_write}, {31'd0, e.mw});
    cmp({t, ".stall_req"},     {31'd0, bus.stall_req},    {31'd0, e.stall});
  endtask

  initial begin
    bus.flush = 1'b0;
    id_idle();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Reset: everything clears, func reads as ADD
    rst = 1'b1;
    tick(); tick();
    expect_out("reset", 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    check_pop();
    rst = 1'b0;
    tick();
    expect_out("idle", 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    check_pop();

    // ADD x3,x1,x2 with data 5,7; no hazards
    set_id(1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 4'd0, 0, 0, 1, 0, 0);
    expect_out("add", 32'd5, 32'd7, 32'd7, 4'd0, 5'd3, 1, 1, 0, 0, 0);
    tick();
    id_idle();
    check_pop();

    // SUB x6,x3,x2 with stale x3 data; MEM and WB both produce x3
    set_id(1, 32'h104, 5'd3, 32'hDEAD, 5'd2, 32'd7, 32'd0, 5'd6, 4'd1, 0, 0, 1, 0, 0);
    tick();
    id_idle();
    set_fwd(5'd3, 1, 32'h10, 5'd3, 1, 32'h20);
    expect_out("fwd_mem_prio", 32'h10, 32'd7, 32'd7, 4'd1, 5'd6, 1, 1, 0, 0, 0);
    #1 check_pop();
    set_fwd(5'd3, 0, 32'h10, 5'd3, 1, 32'h20);
    expect_out("fwd_wb_only", 32'h20, 32'd7, 32'd7, 4'd1, 5'd6, 1, 1, 0, 0, 0);
    #1 check_pop();
    set_fwd(5'd3, 0, 32'h10, 5'd0, 1, 32'h20);
    expect_out("fwd_wb_rd0", 32'hDEAD, 32'd7, 32'd7, 4'd1, 5'd6, 1, 1, 0, 0, 0);
    #1 check_pop();
    set_fwd(0, 0, 0, 0, 0, 0);

    // OR x8,x2,x0: writes to x0 in MEM/WB must never be bypassed
    set_id(1, 32'h108, 5'd2, 32'd7, 5'd0, 32'd0, 32'd0, 5'd8, 4'd6, 0, 0, 1, 0, 0);
    tick();
    id_idle();
    set_fwd(5'd0, 1, 32'h55, 5'd0, 1, 32'h66);
    expect_out("x0_no_fwd", 32'd7, 32'd0, 32'd0, 4'd6, 5'd8, 1, 1, 0, 0, 0);
    #1 check_pop();
    set_fwd(0, 0, 0, 0, 0, 0);

    // LW x4,8(x1) then ADD x5,x4,x1: one stall, one bubble, then forward from WB
    set_id(1, 32'h10C, 5'd1, 32'd5, 5'd0, 32'd0, 32'd8, 5'd4, 4'd0, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 32'h110, 5'd4, 32'h1111, 5'd1, 32'd5, 32'd0, 5'd5, 4'd0, 0, 0, 1, 0, 0);
    expect_out("lw_stall", 32'd5, 32'd8, 32'd0, 4'd0, 5'd4, 1, 1, 1, 0, 1);
    #1 check_pop();
    tick();
    set_fwd(5'd4, 1, 32'h3333, 0, 0, 0);
    expect_out("lw_bubble", 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    #1 check_pop();
    tick();
    id_idle();
    set_fwd(0, 0, 0, 5'd4, 1, 32'h99);
    expect_out("lw_consumer", 32'h99, 32'd5, 32'd5, 4'd0, 5'd5, 1, 1, 0, 0, 0);
    #1 check_pop();
    set_fwd(0, 0, 0, 0, 0, 0);

    // LW x9: rs2 match ignored for an immediate op, honoured for a store
    set_id(1, 32'h114, 5'd1, 32'd5, 5'd0, 32'd0, 32'd4, 5'd9, 4'd0, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 32'h118, 5'd1, 32'd5, 5'd9, 32'd0, 32'd1, 5'd10, 4'd0, 0, 1, 1, 0, 0);
    expect_out("rs2_imm_nostall", 32'd5, 32'd4, 32'd0, 4'd0, 5'd9, 1, 1, 1, 0, 0);
    #1 check_pop();
    set_id(1, 32'h118, 5'd1, 32'd5, 5'd9, 32'd0, 32'd0, 5'd0, 4'd0, 0, 1, 0, 0, 1);
    expect_out("rs2_store_stall", 32'd5, 32'd4, 32'd0, 4'd0, 5'd9, 1, 1, 1, 0, 1);
    #1 check_pop();

    // Flush with a pending stall and a valid ID instruction: plain bubble
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    id_idle();
    expect_out("flush_bubble", 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    #1 check_pop();

    // SW x5,12(x1): imm on src2, store data forwarded from MEM
    set_id(1, 32'h11C, 5'd1, 32'd5, 5'd5, 32'd1, 32'd12, 5'd0, 4'd0, 0, 1, 0, 0, 1);
    tick();
    id_idle();
    set_fwd(5'd5, 1, 32'hAB, 0, 0, 0);
    expect_out("sw_fwd", 32'd5, 32'd12, 32'hAB, 4'd0, 5'd0, 1, 0, 0, 1, 0);
    #1 check_pop();
    set_fwd(0, 0, 0, 0, 0, 0);

    // PC-relative XOR: operand1 from PC, operand2 from immediate
    set_id(1, 32'h200, 5'd0, 32'd0, 5'd0, 32'd0, 32'h1000, 5'd11, 4'd7, 1, 1, 1, 0, 0);
    tick();
    id_idle();
    expect_out("pc_imm", 32'h200, 32'h1000, 32'd0, 4'd7, 5'd11, 1, 1, 0, 0, 0);
    #1 check_pop();

    // Reset arriving mid-stall: bubble and the stall drops
    set_id(1, 32'h204, 5'd1, 32'd5, 5'd0, 32'd0, 32'd0, 5'd4, 4'd0, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 32'h208, 5'd2, 32'd7, 5'd4, 32'd0, 32'd0, 5'd12, 4'd5, 0, 0, 1, 0, 0);
    expect_out("rs2_stall_pre_rst", 32'd5, 32'd0, 32'd0, 4'd0, 5'd4, 1, 1, 1, 0, 1);
    #1 check_pop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst_mid_stall", 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    #1 check_pop();

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
